sipo_shift_receiver: RTL and testbench
======================================

Name: sipo_shift_receiver

Overview:
- Serial-to-parallel receiver. It is the receive end of the cube's MSB-first serial link, driven by a PISO shift register.
- Samples ser_in on each shift strobe and assembles WIDTH-bit words MSB-first.
- Presents each completed word on a held parallel output with a valid/ready handshake.
- Flags overrun when a new word completes before the held word has been consumed. Sits between the serial link and the frame/layer buffer logic.

Parameters:
- WIDTH, 8, data bits per word (minimum 2).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ser_in  input  1  serial data; first bit received is the word MSB.
- shift  input  1  single-cycle strobe; sample ser_in this cycle.
- frame_start  input  1  resynchronise; the bit counter restarts at the first bit.
- par_out  output  WIDTH  last completed word, held stable while out_valid=1.
- out_valid  output  1  par_out holds an unconsumed word.
- out_ready  input  1  consumer accepts par_out when out_valid=1.
- overrun  output  1  sticky; a completed word was dropped.
- clear_overrun  input  1  synchronous clear of overrun.
- parity_err  output  1  parity status of the word in par_out (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high): on a clk edge with reset=1, clear the shift register, bit_cnt, par_out, out_valid, overrun and parity_err to 0. The holding state becomes EMPTY. Reset overrides all other inputs, including mid-word and mid-handshake.
- Shift: on shift=1, shift_reg <= {shift_reg[WIDTH-2:0], ser_in} and bit_cnt increments.
- Word completion: when shift=1 and bit_cnt=FRAME_LEN-1, the word is complete.
  - The completed word {shift_reg[WIDTH-2:0], ser_in} is written to par_out on that same edge.
  - out_valid is 1 in the following cycle, i.e. 1-cycle latency from the final shift strobe.
  - bit_cnt wraps to 0.
- Holding state machine (EMPTY, FULL):
  - EMPTY + completion -> FULL: load par_out, out_valid=1.
  - FULL + out_ready, no completion -> EMPTY: out_valid=0; par_out keeps its last value.
  - FULL + out_ready + completion on the same edge -> stays FULL: par_out reloads with the new word; no overrun.
  - FULL + completion without out_ready: the new word is dropped, par_out is unchanged, overrun is set to 1.
- overrun is sticky:
  - Cleared only by clear_overrun or reset.
  - If clear_overrun and a new overrun event occur on the same edge, the set wins.
- frame_start:
  - Alone: clears bit_cnt and shift_reg; the holding register is unaffected.
  - Together with shift: ser_in is taken as bit 0 of a new word (shift_reg = {0..., ser_in}, bit_cnt = 1).
  - A partial word in progress is discarded silently.
- Strobes arriving while shift=0 have no effect on the datapath. Consecutive shift strobes on every cycle are supported.
- No combinational path from any input to any output.

Optional Feature:
- Macro: SIPO_SHIFT_RECEIVER_PARITY_EN.
- Defined:
  - FRAME_LEN = WIDTH+1. The extra trailing bit is even parity over the WIDTH data bits and is not stored in par_out.
  - parity_err is loaded alongside par_out. It is 1 if the XOR of the data bits and the parity bit is 1.
  - parity_err follows the same hold, reload and drop rules as par_out.
- Undefined:
  - FRAME_LEN = WIDTH.
  - parity_err is tied to 0.

Decomposition:
- Package sipo_pkg:
  - holding-state enum (ST_EMPTY, ST_FULL);
  - function cnt_width(FRAME_LEN) = clog2(FRAME_LEN+1);
  - constant PARITY_BITS (0 or 1, set by the macro).
- One sub-module, sipo_bit_counter: a bit counter with clear, load-1, increment and wrap at FRAME_LEN-1. It outputs bit_cnt and last_bit.
- Shift register, holding register and FSM stay in the top module.

Test Plan (WIDTH=8, macro undefined unless stated):
- Reset, then 8 shift strobes carrying bits 1,0,1,0,0,1,0,1 with out_ready=0 -> one cycle after the 8th strobe, par_out=8'hA5 and out_valid=1; par_out holds until handshake.
- 8'hA5 held, out_ready=1 for one cycle -> out_valid=0 on the next cycle; par_out still 8'hA5; overrun=0.
- 8'hA5 held, out_ready=0, stream 8'h3C -> par_out stays 8'hA5, overrun=1. Then pulse clear_overrun -> overrun=0.
- 8'h3C held, out_ready=1 on the same cycle as the final strobe of 8'hC3 -> par_out=8'hC3, out_valid stays 1, overrun=0.
- 3 bits shifted, then frame_start together with shift (ser_in=1), then 7 bits 1,1,1,1,1,1,1 -> par_out=8'hFF; the partial bits are discarded.
- Macro defined: stream 8'hA5 plus parity bit 0 -> parity_err=0. Stream 8'hA5 plus parity bit 1 -> parity_err=1. Reset asserted mid-frame -> all outputs 0 and the next 9 bits form a clean frame.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-to-parallel receiver.
// Optional trailing even-parity bit is enabled by SIPO_SHIFT_RECEIVER_PARITY_EN.
package sipo_pkg;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } hold_state_t;

`ifdef SIPO_SHIFT_RECEIVER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Counter must be able to hold every value 0..frame_len.
  function automatic int cnt_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

  // XOR reduction; callers zero-extend narrower words (words up to 64 bits).
  function automatic logic parity_of(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Bit position counter for the serial receiver: clear, load-1, increment, wrap.
// last_bit marks the final bit position of a frame.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int CW        = cnt_width(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          shift,
  input  logic          frame_start,
  output logic [CW-1:0] bit_cnt,
  output logic          last_bit
);

  localparam logic [CW-1:0] LAST_POS = CW'(FRAME_LEN - 1);

  // Bit position register; frame_start with a strobe makes that bit position 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= {CW{1'b0}};
    end else if (frame_start && shift) begin
      bit_cnt <= CW'(1);
    end else if (frame_start) begin
      bit_cnt <= {CW{1'b0}};
    end else if (shift && (bit_cnt == LAST_POS)) begin
      bit_cnt <= {CW{1'b0}};
    end else if (shift) begin
      bit_cnt <= bit_cnt + CW'(1);
    end else begin
      bit_cnt <= bit_cnt;
    end
  end

  assign last_bit = (bit_cnt == LAST_POS);

endmodule

// File: rtl/sipo_shift_receiver.sv
// MSB-first serial-to-parallel receiver with held output and valid/ready handshake.
// Define SIPO_SHIFT_RECEIVER_PARITY_EN to expect a trailing even-parity bit per word.
module sipo_shift_receiver
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             shift,
  input  logic             frame_start,
  output logic [WIDTH-1:0] par_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clear_overrun,
  output logic             parity_err
);

  localparam int FRAME_LEN = WIDTH + PARITY_BITS;
  localparam int CW        = cnt_width(FRAME_LEN);

  logic [WIDTH-1:0] shift_reg_r;
  logic [CW-1:0]    bit_cnt_unused_s;
  logic             last_bit_s;
  logic             complete_s;
  logic [WIDTH-1:0] word_s;
  logic             word_perr_s;
  hold_state_t      state_r;

  sipo_bit_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CW        (CW)
  ) u_bit_counter (
    .clk         (clk),
    .reset       (reset),
    .shift       (shift),
    .frame_start (frame_start),
    .bit_cnt     (bit_cnt_unused_s),
    .last_bit    (last_bit_s)
  );

  // A strobe together with frame_start is bit 0 of a new word, never a completion.
  assign complete_s = shift && last_bit_s && !frame_start;

  // Assemble the completed word and its parity status.
  always_comb begin
    word_s      = {shift_reg_r[WIDTH-2:0], ser_in};
    word_perr_s = 1'b0;
`ifdef SIPO_SHIFT_RECEIVER_PARITY_EN
    // Final strobe carries the parity bit; the data bits are already in shift_reg_r.
    word_s      = shift_reg_r;
    word_perr_s = parity_of(64'(shift_reg_r)) ^ ser_in;
`endif
  end

  // Serial shift register, cleared or reseeded on frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg_r <= {WIDTH{1'b0}};
    end else if (frame_start && shift) begin
      shift_reg_r <= {{(WIDTH-1){1'b0}}, ser_in};
    end else if (frame_start) begin
      shift_reg_r <= {WIDTH{1'b0}};
    end else if (shift) begin
      shift_reg_r <= {shift_reg_r[WIDTH-2:0], ser_in};
    end else begin
      shift_reg_r <= shift_reg_r;
    end
  end

  // Holding FSM with registered outputs; a drop setting overrun overrides clear_overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_EMPTY;
      par_out    <= {WIDTH{1'b0}};
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (clear_overrun) begin
        overrun <= 1'b0;
      end
      case (state_r)
        ST_EMPTY: begin
          if (complete_s) begin
            state_r    <= ST_FULL;
            par_out    <= word_s;
            parity_err <= word_perr_s;
            out_valid  <= 1'b1;
          end
        end
        ST_FULL: begin
          if (complete_s && out_ready) begin
            par_out    <= word_s;
            parity_err <= word_perr_s;
          end else if (complete_s) begin
            overrun <= 1'b1;
          end else if (out_ready) begin
            state_r   <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_shift_receiver.sv
// Directed self-checking bench for sipo_shift_receiver (WIDTH=8).
// Parity scenarios run when SIPO_SHIFT_RECEIVER_PARITY_EN is defined.
module tb_sipo_shift_receiver;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             ser_in;
  logic             shift;
  logic             frame_start;
  logic [WIDTH-1:0] par_out;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             clear_overrun;
  logic             parity_err;

  int passed = 0;
  int total  = 0;

  sipo_shift_receiver #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .ser_in        (ser_in),
    .shift         (shift),
    .frame_start   (frame_start),
    .par_out       (par_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .parity_err    (parity_err)
  );

  always #5 clk = ~clk;

  // Streams bits[n-1] down to bits[0] on consecutive strobes, starting at a negedge.
  task automatic send_bits(input logic [15:0] bits, input int n,
                           input logic ready_last, input logic clr_last);
    for (int i = n - 1; i >= 0; i--) begin
      ser_in = bits[i];
      shift  = 1'b1;
      if (i == 0) begin
        out_ready     = ready_last;
        clear_overrun = clr_last;
      end
      @(negedge clk);
    end
    shift = 1'b0; ser_in = 1'b0; out_ready = 1'b0; clear_overrun = 1'b0;
  endtask

  task automatic pulse_ready();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (par_out !== 8'h00) $display("FAIL reset_par_out: got %h expected %h", par_out, 8'h00); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected %b", out_valid, 1'b0); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected %b", overrun, 1'b0); else passed++;
    total++; if (parity_err !== 1'b0) $display("FAIL reset_parity_err: got %b expected %b", parity_err, 1'b0); else passed++;
    reset = 1'b0;
  endtask

`ifdef SIPO_SHIFT_RECEIVER_PARITY_EN
  task automatic test_parity();
    send_bits({7'd0, 8'hA5, 1'b0}, 9, 1'b0, 1'b0);
    total++; if (par_out !== 8'hA5) $display("FAIL par_good_data: got %h expected %h", par_out, 8'hA5); else passed++;
    total++; if (parity_err !== 1'b0) $display("FAIL par_good_err: got %b expected %b", parity_err, 1'b0); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL par_good_valid: got %b expected %b", out_valid, 1'b1); else passed++;
    pulse_ready();
    send_bits({7'd0, 8'hA5, 1'b1}, 9, 1'b0, 1'b0);
    total++; if (par_out !== 8'hA5) $display("FAIL par_bad_data: got %h expected %h", par_out, 8'hA5); else passed++;
    total++; if (parity_err !== 1'b1) $display("FAIL par_bad_err: got %b expected %b", parity_err, 1'b1); else passed++;
    // Reset mid-frame with a strobe present.
    send_bits(16'h000F, 4, 1'b0, 1'b0);
    reset = 1'b1; shift = 1'b1; ser_in = 1'b1;
    @(negedge clk);
    reset = 1'b0; shift = 1'b0; ser_in = 1'b0;
    total++; if (par_out !== 8'h00) $display("FAIL par_rst_data: got %h expected %h", par_out, 8'h00); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL par_rst_valid: got %b expected %b", out_valid, 1'b0); else passed++;
    total++; if (parity_err !== 1'b0) $display("FAIL par_rst_err: got %b expected %b", parity_err, 1'b0); else passed++;
    send_bits({7'd0, 8'h3C, 1'b0}, 9, 1'b0, 1'b0);
    total++; if (par_out !== 8'h3C) $display("FAIL par_clean_data: got %h expected %h", par_out, 8'h3C); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL par_clean_valid: got %b expected %b", out_valid, 1'b1); else passed++;
    total++; if (parity_err !== 1'b0) $display("FAIL par_clean_err: got %b expected %b", parity_err, 1'b0); else passed++;
  endtask
`else
  task automatic test_receive();
    send_bits(16'h00A5, 8, 1'b0, 1'b0);
    total++; if (par_out !== 8'hA5) $display("FAIL recv_par_out: got %h expected %h", par_out, 8'hA5); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL recv_valid: got %b expected %b", out_valid, 1'b1); else passed++;
    // Idle with toggling ser_in but no strobe: nothing may move.
    for (int i = 0; i < 3; i++) begin
      ser_in = ~ser_in;
      @(negedge clk);
    end
    ser_in = 1'b0;
    total++; if (par_out !== 8'hA5) $display("FAIL recv_hold_par_out: got %h expected %h", par_out, 8'hA5); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL recv_hold_valid: got %b expected %b", out_valid, 1'b1); else passed++;
  endtask

  task automatic test_handshake();
    pulse_ready();
    total++; if (out_valid !== 1'b0) $display("FAIL hs_valid: got %b expected %b", out_valid, 1'b0); else passed++;
    total++; if (par_out !== 8'hA5) $display("FAIL hs_par_out: got %h expected %h", par_out, 8'hA5); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL hs_overrun: got %b expected %b", overrun, 1'b0); else passed++;
  endtask

  task automatic test_overrun();
    send_bits(16'h00A5, 8, 1'b0, 1'b0);
    send_bits(16'h003C, 8, 1'b0, 1'b0);
    total++; if (par_out !== 8'hA5) $display("FAIL ovr_par_out: got %h expected %h", par_out, 8'hA5); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b expected %b", overrun, 1'b1); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL ovr_valid: got %b expected %b", out_valid, 1'b1); else passed++;
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    total++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b expected %b", overrun, 1'b0); else passed++;
    pulse_ready();
    send_bits(16'h003C, 8, 1'b0, 1'b0);
    total++; if (par_out !== 8'h3C) $display("FAIL ovr_next_par_out: got %h expected %h", par_out, 8'h3C); else passed++;
  endtask

  task automatic test_back_to_back();
    send_bits(16'h00C3, 8, 1'b1, 1'b0);
    total++; if (par_out !== 8'hC3) $display("FAIL b2b_par_out: got %h expected %h", par_out, 8'hC3); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid: got %b expected %b", out_valid, 1'b1); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b expected %b", overrun, 1'b0); else passed++;
  endtask

  task automatic test_overrun_priority();
    send_bits(16'h0055, 8, 1'b0, 1'b1);
    total++; if (overrun !== 1'b1) $display("FAIL prio_overrun: got %b expected %b", overrun, 1'b1); else passed++;
    total++; if (par_out !== 8'hC3) $display("FAIL prio_par_out: got %h expected %h", par_out, 8'hC3); else passed++;
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    pulse_ready();
  endtask

  task automatic test_frame_start();
    send_bits(16'h0000, 3, 1'b0, 1'b0);
    frame_start = 1'b1; shift = 1'b1; ser_in = 1'b1;
    @(negedge clk);
    frame_start = 1'b0; shift = 1'b0; ser_in = 1'b0;
    send_bits(16'h007F, 7, 1'b0, 1'b0);
    total++; if (par_out !== 8'hFF) $display("FAIL fs_shift_par_out: got %h expected %h", par_out, 8'hFF); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL fs_shift_valid: got %b expected %b", out_valid, 1'b1); else passed++;
    pulse_ready();
    // frame_start alone drops a partial word.
    send_bits(16'h0003, 2, 1'b0, 1'b0);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL fs_alone_valid: got %b expected %b", out_valid, 1'b0); else passed++;
    send_bits(16'h0081, 8, 1'b0, 1'b0);
    total++; if (par_out !== 8'h81) $display("FAIL fs_alone_par_out: got %h expected %h", par_out, 8'h81); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL fs_alone_overrun: got %b expected %b", overrun, 1'b0); else passed++;
  endtask
`endif

  initial begin
    reset = 1'b1; ser_in = 1'b0; shift = 1'b0; frame_start = 1'b0;
    out_ready = 1'b0; clear_overrun = 1'b0;
    @(negedge clk);
    test_reset();
`ifdef SIPO_SHIFT_RECEIVER_PARITY_EN
    test_parity();
`else
    test_receive();
    test_handshake();
    test_overrun();
    test_back_to_back();
    test_overrun_priority();
    test_frame_start();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
